// File: rtl/arb_mux_pkg.sv
// Shared types and helpers for the round-robin arbitrating mux.
// The lock FSM states are only used when ARB_MUX_LOCK_EN is defined.
package arb_mux_pkg;

    localparam int unsigned ARB_MUX_MAX_N = 16;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_state_e;

    // First index to search after a grant at ptr, wrapping at n.
    function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
        return (ptr + 32'd1 >= n) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches req starting at ptr+1, or
// grants only force_idx when force_en is high.
module rr_arbiter
    import arb_mux_pkg::*;
#(
    parameter  int unsigned N      = 4,
    localparam int unsigned CHAN_W = $clog2(N)
) (
    input  logic [N-1:0]      req,
    input  logic [CHAN_W-1:0] ptr,
    input  logic              en,
    input  logic              force_en,
    input  logic [CHAN_W-1:0] force_idx,
    output logic [N-1:0]      gnt,
    output logic [CHAN_W-1:0] gnt_idx,
    output logic              any
);

    int unsigned w_start;

    assign w_start = rr_next(32'(ptr), N);

    always_comb begin
        int unsigned w_idx;
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        w_idx   = 0;
        if (en) begin
            if (force_en) begin
                if (req[force_idx]) begin
                    gnt[force_idx] = 1'b1;
                    gnt_idx        = force_idx;
                    any            = 1'b1;
                end
            end else begin
                for (int unsigned k = 0; k < N; k++) begin
                    w_idx = w_start + k;
                    if (w_idx >= N) begin
                        w_idx = w_idx - N;
                    end
                    if (!any && req[CHAN_W'(w_idx)]) begin
                        gnt[CHAN_W'(w_idx)] = 1'b1;
                        gnt_idx             = CHAN_W'(w_idx);
                        any                 = 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/rr_arb_mux.sv
// N-channel round-robin arbitrating mux with a single registered output stage.
// Define ARB_MUX_LOCK_EN to hold the grant on one channel until its in_last beat.
module rr_arb_mux
    import arb_mux_pkg::*;
#(
    parameter  int unsigned N      = 4,
    parameter  int unsigned WIDTH  = 8,
    localparam int unsigned CHAN_W = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         in_valid,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic [N-1:0]         in_last,
    output logic [N-1:0]         in_ready,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_last,
    output logic [CHAN_W-1:0]    out_chan,
    input  logic                 out_ready
);

    logic                 r_out_valid;
    logic [WIDTH-1:0]     r_out_data;
    logic                 r_out_last;
    logic [CHAN_W-1:0]    r_out_chan;
    logic [CHAN_W-1:0]    r_ptr;

    logic                 w_ld;
    logic                 w_en;
    logic [N-1:0]         w_gnt;
    logic [CHAN_W-1:0]    w_gnt_idx;
    logic                 w_any;
    logic [WIDTH-1:0]     w_data;
    logic                 w_last;
    logic                 w_force_en;
    logic [CHAN_W-1:0]    w_force_idx;

    assign w_ld = !r_out_valid || out_ready;
    // Keeps in_ready low while reset is asserted, even with requests pending.
    assign w_en = w_ld && rst_n;

`ifdef ARB_MUX_LOCK_EN
    lock_state_e          r_lock_state;
    logic [CHAN_W-1:0]    r_lock_chan;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lock_state <= UNLOCKED;
            r_lock_chan  <= '0;
        end else if (w_any) begin
            case (r_lock_state)
                UNLOCKED: begin
                    if (!w_last) begin
                        r_lock_state <= LOCKED;
                        r_lock_chan  <= w_gnt_idx;
                    end
                end
                LOCKED: begin
                    if (w_last) begin
                        r_lock_state <= UNLOCKED;
                    end
                end
                default: r_lock_state <= UNLOCKED;
            endcase
        end
    end

    assign w_force_en  = (r_lock_state == LOCKED);
    assign w_force_idx = r_lock_chan;
`else
    assign w_force_en  = 1'b0;
    assign w_force_idx = '0;
`endif

    rr_arbiter #(
        .N (N)
    ) u_arb (
        .req       (in_valid),
        .ptr       (r_ptr),
        .en        (w_en),
        .force_en  (w_force_en),
        .force_idx (w_force_idx),
        .gnt       (w_gnt),
        .gnt_idx   (w_gnt_idx),
        .any       (w_any)
    );

    // One-hot select keeps in_data off the in_ready path.
    always_comb begin
        w_data = '0;
        w_last = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (w_gnt[i]) begin
                w_data = in_data[i*WIDTH +: WIDTH];
                w_last = in_last[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_out_chan  <= '0;
            r_ptr       <= CHAN_W'(N - 1);
        end else if (w_ld) begin
            r_out_valid <= w_any;
            if (w_any) begin
                r_out_data <= w_data;
                r_out_last <= w_last;
                r_out_chan <= w_gnt_idx;
                r_ptr      <= w_gnt_idx;
            end
        end
    end

    assign in_ready  = w_gnt;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;
    assign out_chan  = r_out_chan;

endmodule

// File: tb/tb_rr_arb_mux.sv
// Directed self-checking bench for rr_arb_mux (N=4, WIDTH=8); lock expectations
// follow ARB_MUX_LOCK_EN when the bench is built with it.
module tb_rr_arb_mux;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  in_valid;
    logic [31:0] in_data;
    logic [3:0]  in_last;
    logic [3:0]  in_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_last;
    logic [1:0]  out_chan;
    logic        out_ready;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rr_arb_mux #(
        .N     (4),
        .WIDTH (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_chan  (out_chan),
        .out_ready (out_ready)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n     = 1'b0;
        in_valid  = 4'hF;
        in_data   = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        in_last   = 4'hF;
        out_ready = 1'b1;
        tick();
        tick();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        checks++;
        if (out_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", out_data); end
        checks++;
        if (out_chan !== 2'd0) begin errors++; $display("FAIL reset_chan: got %0d want 0", out_chan); end
        checks++;
        if (out_last !== 1'b0) begin errors++; $display("FAIL reset_last: got %b want 0", out_last); end
        checks++;
        if (in_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready: got %b want 0000", in_ready); end
        #2;
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 4'b0001) begin errors++; $display("FAIL first_grant: got %b want 0001", in_ready); end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_chan !== 2'd0 || out_data !== 8'hA0) begin
            errors++;
            $display("FAIL first_word: got v=%b ch=%0d d=%h want v=1 ch=0 d=a0", out_valid, out_chan, out_data);
        end
    endtask

    task automatic test_round_robin;
        logic [1:0] c;
        logic [3:0] exp_rdy;
        for (int k = 1; k < 8; k++) begin
            c = 2'(k % 4);
            exp_rdy = 4'b0001 << c;
            checks++;
            if (in_ready !== exp_rdy) begin
                errors++;
                $display("FAIL rr_ready[%0d]: got %b want %b", k, in_ready, exp_rdy);
            end
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_chan !== c || out_data !== (8'hA0 + 8'(c)) || out_last !== 1'b1) begin
                errors++;
                $display("FAIL rr_word[%0d]: got v=%b ch=%0d d=%h l=%b want v=1 ch=%0d d=%h l=1",
                         k, out_valid, out_chan, out_data, out_last, c, 8'hA0 + 8'(c));
            end
        end
    endtask

    task automatic test_backpressure;
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if (in_ready !== 4'b0000) begin errors++; $display("FAIL stall_ready[%0d]: got %b want 0000", k, in_ready); end
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_chan !== 2'd3 || out_data !== 8'hA3) begin
                errors++;
                $display("FAIL stall_hold[%0d]: got v=%b ch=%0d d=%h want v=1 ch=3 d=a3", k, out_valid, out_chan, out_data);
            end
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 4'b0001) begin errors++; $display("FAIL release_ready: got %b want 0001", in_ready); end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_chan !== 2'd0 || out_data !== 8'hA0) begin
            errors++;
            $display("FAIL release_word: got v=%b ch=%0d d=%h want v=1 ch=0 d=a0", out_valid, out_chan, out_data);
        end
    endtask

    task automatic test_sparse;
        logic [1:0] c;
        in_valid = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            c = (k % 2 == 0) ? 2'd1 : 2'd3;
            #1;
            checks++;
            if (in_ready !== (4'b0001 << c)) begin
                errors++;
                $display("FAIL sparse_ready[%0d]: got %b want %b", k, in_ready, 4'b0001 << c);
            end
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_chan !== c || out_data !== (8'hA0 + 8'(c))) begin
                errors++;
                $display("FAIL sparse_word[%0d]: got v=%b ch=%0d d=%h want v=1 ch=%0d", k, out_valid, out_chan, out_data, c);
            end
        end
        in_valid = 4'b0000;
        #1;
        checks++;
        if (in_ready !== 4'b0000) begin errors++; $display("FAIL idle_ready: got %b want 0000", in_ready); end
        tick();
        checks++;
        if (out_valid !== 1'b0 || out_chan !== 2'd3 || out_data !== 8'hA3) begin
            errors++;
            $display("FAIL drain_empty: got v=%b ch=%0d d=%h want v=0 ch=3 d=a3", out_valid, out_chan, out_data);
        end
    endtask

    task automatic test_lock;
        logic [1:0] exp_seq [5];
        logic [7:0] exp_d;
        int beat;
`ifdef ARB_MUX_LOCK_EN
        exp_seq = '{2'd2, 2'd2, 2'd2, 2'd0, 2'd0};
`else
        exp_seq = '{2'd2, 2'd0, 2'd2, 2'd0, 2'd2};
`endif
        in_valid = 4'b0010;
        in_last  = 4'hF;
        tick();
        beat = 0;
        in_valid = 4'b0101;
        for (int k = 0; k < 5; k++) begin
            in_data[16 +: 8] = 8'hB0 + 8'(beat);
            in_last[2]       = (beat == 2);
            in_last[0]       = 1'b1;
            #1;
            checks++;
            if (in_ready !== (4'b0001 << exp_seq[k])) begin
                errors++;
                $display("FAIL lock_ready[%0d]: got %b want %b", k, in_ready, 4'b0001 << exp_seq[k]);
            end
            exp_d = (exp_seq[k] == 2'd2) ? 8'hB0 + 8'(beat) : 8'hA0;
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_chan !== exp_seq[k] || out_data !== exp_d) begin
                errors++;
                $display("FAIL lock_word[%0d]: got v=%b ch=%0d d=%h want v=1 ch=%0d d=%h",
                         k, out_valid, out_chan, out_data, exp_seq[k], exp_d);
            end
            if (exp_seq[k] == 2'd2) begin
                beat++;
                if (beat == 3) in_valid[2] = 1'b0;
            end
        end
        in_valid = 4'b0000;
        tick();
    endtask

    task automatic test_reset_mid_packet;
        in_data  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        in_valid = 4'b0100;
        in_last  = 4'b1011;
        tick();
        out_ready = 1'b0;
        in_valid  = 4'b0101;
        checks++;
        if (out_valid !== 1'b1 || out_chan !== 2'd2) begin
            errors++;
            $display("FAIL pre_reset_word: got v=%b ch=%0d want v=1 ch=2", out_valid, out_chan);
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_chan !== 2'd0 || out_data !== 8'h00 || in_ready !== 4'b0000) begin
            errors++;
            $display("FAIL async_reset: got v=%b ch=%0d d=%h rdy=%b want v=0 ch=0 d=00 rdy=0000",
                     out_valid, out_chan, out_data, in_ready);
        end
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 4'b0001) begin errors++; $display("FAIL post_reset_grant: got %b want 0001", in_ready); end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_chan !== 2'd0 || out_data !== 8'hA0) begin
            errors++;
            $display("FAIL post_reset_word: got v=%b ch=%0d d=%h want v=1 ch=0 d=a0", out_valid, out_chan, out_data);
        end
        in_valid = 4'b0000;
        tick();
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_backpressure();
        test_sparse();
        test_lock();
        test_reset_mid_packet();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
